fmul_arbiter: RTL and testbench
===============================

// Module: fmul_arbiter
// PURPOSE
//  Shares one fmul unit among NREQ requesters (FPU issue ports, fdiv/fsqrt iteration engines).
//  fmul registers its partial products at a clock edge. Its exponent and sign paths stay
//  combinational on x1/x2, so operands must be held for two cycles: EXEC, then CAPT.
//  This block does round-robin arbitration, holds the operands and captures y.
//  It returns each result to the owning requester over a valid/ready response.
// PARAMETERS
//  NREQ  4  number of requesters (2..8); the id width is $clog2(NREQ)
// PORTS
//  clk         in   1          clock; all state updates on posedge
//  rst         in   1          reset, asynchronous, active-high
//  req_valid   in   NREQ       per-requester operand valid
//  req_x1      in   NREQ x 32  per-requester operand 1 (IEEE single)
//  req_x2      in   NREQ x 32  per-requester operand 2
//  req_ready   out  NREQ       one-hot grant; a handshake is req_valid[i] & req_ready[i]
//  resp_valid  out  NREQ       one-hot; result available to requester i
//  resp_y      out  32         product; stable while any resp_valid bit is high
//  resp_ready  in   NREQ       requester i accepts resp_y
//  fm_x1       out  32         to fmul.x1, registered
//  fm_x2       out  32         to fmul.x2, registered
//  fm_y        in   32         from fmul.y
// BEHAVIOUR
//  Reset: state=IDLE; fm_x1=fm_x2=0; resp_valid=0; resp_y=0; rr_ptr=0; in-flight op discarded.
//  No response is ever issued for an op discarded by reset.
//  FSM IDLE -> EXEC -> CAPT -> RESP -> (IDLE | EXEC).
//  Accept window: state==IDLE, or state==RESP with the response handshake in the same cycle.
//   - Within the window, req_ready is the combinational one-hot grant from the round-robin arbiter.
//   - Outside the window, req_ready=0.
//  Round robin: search starts at rr_ptr; after a grant to i, rr_ptr <= (i+1) mod NREQ.
//   - If only one requester is valid, it is granted every window; no idle gap is inserted.
//  Accept edge (cycle c0): fm_x1/fm_x2 <= granted operands; owner id registered; state <= EXEC.
//  EXEC (c1): fmul loads its product registers at the end of the cycle.
//  CAPT (c2): fm_y is valid; resp_y <= fm_y; state <= RESP.
//   - fm_x1/fm_x2 are held unchanged through EXEC and CAPT.
//  RESP (c3+): resp_valid[owner]=1 until resp_ready[owner]; the other resp_ready bits are ignored.
//   - Latency from accept to resp_valid is 3 cycles; peak throughput is 1 op per 3 cycles.
//   - If the handshake occurs and a new grant is made in the same cycle, go to EXEC.
//   - If the handshake occurs with no grant, go to IDLE.
//   - If resp_ready is low, hold: resp_y, owner and fm_x* stay unchanged (back-pressure).
//  Result value is exactly fmul's output, including zero/denormal handling and exponent behaviour.
//  resp_valid never has more than one bit set; req_ready never has more than one bit set.
// CONFIGURATION
//  FMUL_ARB_ZERO_FAST_EN defined:
//   - At accept, if x1[30:23]==0 or x2[30:23]==0, load resp_y <= {x1[31]^x2[31], 31'b0}.
//   - state <= RESP directly, so resp_valid appears at c1.
//   - fm_x1/fm_x2 are not updated and fmul is not used.
//  FMUL_ARB_ZERO_FAST_EN undefined:
//   - All ops take the EXEC/CAPT path.
//   - Result bits are identical with or without the macro; only latency differs.
// STRUCTURE
//  fpu_arb_pkg:
//   - state enum (IDLE, EXEC, CAPT, RESP)
//   - FP_W=32 and EXP_MSB/EXP_LSB/SIGN constants
//   - typedef fp32_t
//  Sub-module rr_arbiter #(N):
//   - inputs req, ptr, en; output grant one-hot; combinational.
//   - fmul_arbiter owns the rr_ptr register.
//  fmul is instantiated outside; this block exposes only the fm_* ports.
// TESTING (bench includes fmul connected to fm_*)
//  1 Single op: req0 0x3F800000*0x40000000 -> resp_valid[0] at c3, resp_y=0x40000000.
//  2 Contention:
//     - req0..3 valid together, operands 0x3FC00000*0x3FC00000.
//     - Grants go 0,1,2,3 in order; each resp_y=0x40100000.
//     - Back-to-back grants are 3 cycles apart.
//  3 Sign/back-pressure: req2 0xC0400000*0x3F000000.
//     - Hold resp_ready[2]=0 for 5 cycles: resp_y=0xBFC00000 stays stable and req_ready stays 0.
//     - Release: handshake occurs, and a pending req1 is granted in the same cycle.
//  4 Zero operand: 0x00000000*0xC0000000 -> resp_y=0x80000000.
//     - Macro on: resp_valid at c1. Macro off: resp_valid at c3.
//  5 Reset mid-op: assert rst during CAPT.
//     - All outputs go 0 immediately; no response issued.
//     - Next accepted op is granted starting from requester 0.
//  6 Fairness: req1 held valid continuously, req3 toggled.
//     - No requester waits more than NREQ grants.
//     - Checker asserts one-hot req_ready and resp_valid every cycle.

Source files
------------

// File: rtl/fmul_arbiter_pkg.sv
// Shared types and constants for the fmul arbiter: FSM states, the fp32 word type and
// field positions used by the zero-operand fast path (enabled by FMUL_ARB_ZERO_FAST_EN).
package fpu_arb_pkg;

  localparam int FP_W    = 32;
  localparam int SIGN    = 31;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;

  typedef logic [FP_W-1:0] fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_e;

  function automatic logic exp_is_zero(input fp32_t x);
    return x[EXP_MSB:EXP_LSB] == '0;
  endfunction

  function automatic fp32_t signed_zero(input fp32_t a, input fp32_t b);
    return {a[SIGN] ^ b[SIGN], {(FP_W-1){1'b0}}};
  endfunction

endpackage

// File: rtl/fmul_arbiter_if.sv
// Request/response/fmul bundle between the requesters, the arbiter and the shared fmul.
interface fmul_arbiter_if
  import fpu_arb_pkg::*;
#(
  parameter int NREQ = 4
);

  logic  [NREQ-1:0] req_valid;
  fp32_t [NREQ-1:0] req_x1;
  fp32_t [NREQ-1:0] req_x2;
  logic  [NREQ-1:0] req_ready;
  logic  [NREQ-1:0] resp_valid;
  fp32_t            resp_y;
  logic  [NREQ-1:0] resp_ready;
  fp32_t            fm_x1;
  fp32_t            fm_x2;
  fp32_t            fm_y;

  // Requesters plus the external fmul: drives operands/acceptance and fm_y.
  modport master (
    output req_valid, req_x1, req_x2, resp_ready, fm_y,
    input  req_ready, resp_valid, resp_y, fm_x1, fm_x2
  );

  modport slave (
    input  req_valid, req_x1, req_x2, resp_ready, fm_y,
    output req_ready, resp_valid, resp_y, fm_x1, fm_x2
  );

endinterface

// File: rtl/fmul_arbiter_rr.sv
// Combinational round-robin arbiter: one-hot grant to the first set req bit at or after ptr.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant
);

  logic [PW:0] idx;
  logic        found;

  // The extra idx bit lets the wrap work for non-power-of-two N.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) begin
        idx = idx - (PW+1)'(N);
      end
      if (en && !found && req[idx[PW-1:0]]) begin
        grant[idx[PW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmul_arbiter.sv
// Shares one two-cycle fmul among NREQ requesters with round-robin grants and a valid/ready
// response. Define FMUL_ARB_ZERO_FAST_EN to answer zero-exponent operands without fmul.
module fmul_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input logic          clk,
  input logic          rst,
  fmul_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  fp32_t            fm_x1_q, fm_x1_d;
  fp32_t            fm_x2_q, fm_x2_d;
  fp32_t            resp_y_q, resp_y_d;
  logic [NREQ-1:0]  resp_valid_q, resp_valid_d;

  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  owner_oh;
  logic [IDW-1:0]   grant_id;
  logic             any_grant;
  logic             resp_hs;
  logic             accept_en;
  fp32_t            sel_x1;
  fp32_t            sel_x2;

  assign resp_hs   = (state_q == RESP) && bus.resp_ready[owner_q];
  // Gating with rst keeps req_ready low while the block is held in reset.
  assign accept_en = !rst && ((state_q == IDLE) || resp_hs);

  rr_arbiter #(.N(NREQ), .PW(IDW)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .en    (accept_en),
    .grant (grant)
  );

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_owner_oh
      assign owner_oh[gi] = (owner_q == IDW'(gi));
    end
  endgenerate

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_id = IDW'(i);
      end
    end
  end

  assign any_grant = |grant;
  assign sel_x1    = bus.req_x1[grant_id];
  assign sel_x2    = bus.req_x2[grant_id];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    fm_x1_d      = fm_x1_q;
    fm_x2_d      = fm_x2_q;
    resp_y_d     = resp_y_q;
    resp_valid_d = resp_valid_q;

    case (state_q)
      IDLE: ;
      EXEC: state_d = CAPT;
      CAPT: begin
        resp_y_d     = bus.fm_y;
        resp_valid_d = owner_oh;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_hs) begin
          resp_valid_d = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A grant only exists inside the accept window, so it overrides the case defaults.
    if (any_grant) begin
      owner_d  = grant_id;
      rr_ptr_d = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
`ifdef FMUL_ARB_ZERO_FAST_EN
      if (exp_is_zero(sel_x1) || exp_is_zero(sel_x2)) begin
        resp_y_d     = signed_zero(sel_x1, sel_x2);
        resp_valid_d = grant;
        state_d      = RESP;
      end else begin
        fm_x1_d = sel_x1;
        fm_x2_d = sel_x2;
        state_d = EXEC;
      end
`else
      fm_x1_d = sel_x1;
      fm_x2_d = sel_x2;
      state_d = EXEC;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      fm_x1_q      <= '0;
      fm_x2_q      <= '0;
      resp_y_q     <= '0;
      resp_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      fm_x1_q      <= fm_x1_d;
      fm_x2_q      <= fm_x2_d;
      resp_y_q     <= resp_y_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_y     = resp_y_q;
  assign bus.fm_x1      = fm_x1_q;
  assign bus.fm_x2      = fm_x2_q;

endmodule

// File: tb/tb_fmul_arbiter.sv
// Directed bench for fmul_arbiter with a small two-cycle fmul model on the fm_* ports.
module tb_fmul_arbiter;
  import fpu_arb_pkg::*;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  fmul_arbiter_if #(.NREQ(NREQ)) bus ();

  fmul_arbiter #(.NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // fmul model: significand product registered, sign/exponent combinational on x1/x2.
  logic [47:0] fm_p_q;
  int          fm_e;
  always @(posedge clk) fm_p_q <= {1'b1, bus.fm_x1[22:0]} * {1'b1, bus.fm_x2[22:0]};
  always_comb begin
    fm_e = 0;
    if (bus.fm_x1[30:23] == 8'd0 || bus.fm_x2[30:23] == 8'd0) begin
      bus.fm_y = {bus.fm_x1[31] ^ bus.fm_x2[31], 31'b0};
    end else if (fm_p_q[47]) begin
      fm_e = int'(bus.fm_x1[30:23]) + int'(bus.fm_x2[30:23]) - 126;
      bus.fm_y = {bus.fm_x1[31] ^ bus.fm_x2[31], fm_e[7:0], fm_p_q[46:24]};
    end else begin
      fm_e = int'(bus.fm_x1[30:23]) + int'(bus.fm_x2[30:23]) - 127;
      bus.fm_y = {bus.fm_x1[31] ^ bus.fm_x2[31], fm_e[7:0], fm_p_q[45:23]};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input fp32_t a, input fp32_t b);
    bus.req_valid[i] = v;
    bus.req_x1[i]    = a;
    bus.req_x2[i]    = b;
  endtask

  // Every-cycle one-hot checks, fairness bound and one line per completed response.
  int wait_cnt [NREQ];
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    end else begin
      check("onehot_req_ready", 32'($onehot0(bus.req_ready)), 32'd1);
      check("onehot_resp_valid", 32'($onehot0(bus.resp_valid)), 32'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] || bus.req_ready[i]) wait_cnt[i] = 0;
        else if (|bus.req_ready) begin
          wait_cnt[i]++;
          check("fair_wait", 32'(wait_cnt[i] <= NREQ), 32'd1);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.resp_valid[i] && bus.resp_ready[i])
          $display("resp id=%0d y=0x%08h t=%0t", i, bus.resp_y, $time);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] exp_g [8];

  initial begin
    bus.req_valid  = '0;
    bus.req_x1     = '0;
    bus.req_x2     = '0;
    bus.resp_ready = 4'hF;
    step();
    step();
    check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check("rst_resp_y", bus.resp_y, 32'h0);
    check("rst_fm_x1", bus.fm_x1, 32'h0);
    rst = 1'b0;
    step();

    // 1: single op, 1.0 * 2.0
    set_req(0, 1'b1, 32'h3F800000, 32'h40000000);
    #1 check("t1_grant", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid[0] = 1'b0;
    #1 check("t1_exec_rv", 32'(bus.resp_valid), 32'h0);
    check("t1_fm_x1", bus.fm_x1, 32'h3F800000);
    check("t1_fm_x2", bus.fm_x2, 32'h40000000);
    step();
    check("t1_capt_rv", 32'(bus.resp_valid), 32'h0);
    check("t1_capt_fm_x1", bus.fm_x1, 32'h3F800000);
    step();
    check("t1_rv", 32'(bus.resp_valid), 32'h1);
    check("t1_y", bus.resp_y, 32'h40000000);
    step();
    check("t1_idle_rv", 32'(bus.resp_valid), 32'h0);

    // reset pulse so contention starts from requester 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // 2: contention, 1.5 * 1.5 from all four
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32'h3FC00000, 32'h3FC00000);
    #1 check("t2_grant0", 32'(bus.req_ready), 32'h1);
    for (int k = 0; k < NREQ; k++) begin
      step();
      bus.req_valid[k] = 1'b0;
      #1 check("t2_exec_ready", 32'(bus.req_ready), 32'h0);
      step();
      check("t2_capt_rv", 32'(bus.resp_valid), 32'h0);
      step();
      check("t2_rv", 32'(bus.resp_valid), 32'(4'b1 << k));
      check("t2_y", bus.resp_y, 32'h40100000);
      check("t2_next_grant", 32'(bus.req_ready), (k < NREQ-1) ? 32'(4'b1 << (k+1)) : 32'h0);
    end
    step();

    // 3: sign and back-pressure, -3.0 * 0.5, then req1 3.0 * 3.0
    bus.resp_ready = 4'b1011;
    set_req(2, 1'b1, 32'hC0400000, 32'h3F000000);
    #1 check("t3_grant2", 32'(bus.req_ready), 32'h4);
    step();
    bus.req_valid[2] = 1'b0;
    step();
    step();
    set_req(1, 1'b1, 32'h40400000, 32'h40400000);
    #1 check("t3_rv", 32'(bus.resp_valid), 32'h4);
    check("t3_y", bus.resp_y, 32'hBFC00000);
    check("t3_bp_ready", 32'(bus.req_ready), 32'h0);
    for (int c = 0; c < 5; c++) begin
      step();
      check("t3_hold_rv", 32'(bus.resp_valid), 32'h4);
      check("t3_hold_y", bus.resp_y, 32'hBFC00000);
      check("t3_hold_ready", 32'(bus.req_ready), 32'h0);
      check("t3_hold_fm_x1", bus.fm_x1, 32'hC0400000);
    end
    bus.resp_ready = 4'hF;
    #1 check("t3_release_grant1", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid[1] = 1'b0;
    #1 check("t3_after_rv", 32'(bus.resp_valid), 32'h0);
    check("t3_fm_x1_new", bus.fm_x1, 32'h40400000);
    step();
    step();
    check("t3_rv1", 32'(bus.resp_valid), 32'h2);
    check("t3_y1", bus.resp_y, 32'h41100000);
    step();

    // 4: zero operand, 0.0 * -2.0
    set_req(0, 1'b1, 32'h00000000, 32'hC0000000);
    #1 check("t4_grant0", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid[0] = 1'b0;
`ifdef FMUL_ARB_ZERO_FAST_EN
    #1 check("t4_fast_rv", 32'(bus.resp_valid), 32'h1);
    check("t4_fast_y", bus.resp_y, 32'h80000000);
    check("t4_fast_fm_x1", bus.fm_x1, 32'h40400000);
`else
    #1 check("t4_c1_rv", 32'(bus.resp_valid), 32'h0);
    step();
    check("t4_c2_rv", 32'(bus.resp_valid), 32'h0);
    step();
    check("t4_rv", 32'(bus.resp_valid), 32'h1);
    check("t4_y", bus.resp_y, 32'h80000000);
`endif
    step();
    check("t4_idle_rv", 32'(bus.resp_valid), 32'h0);

    // 5: reset during CAPT of a req1 op
    set_req(1, 1'b1, 32'h3F800000, 32'h40000000);
    #1 check("t5_grant1", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid[1] = 1'b0;
    step();
    rst = 1'b1;
    set_req(0, 1'b1, 32'h3FC00000, 32'h3FC00000);
    set_req(3, 1'b1, 32'h3F800000, 32'h40000000);
    #1 check("t5_rst_rv", 32'(bus.resp_valid), 32'h0);
    check("t5_rst_y", bus.resp_y, 32'h0);
    check("t5_rst_fm_x1", bus.fm_x1, 32'h0);
    check("t5_rst_fm_x2", bus.fm_x2, 32'h0);
    check("t5_rst_ready", 32'(bus.req_ready), 32'h0);
    step();
    check("t5_no_resp", 32'(bus.resp_valid), 32'h0);
    rst = 1'b0;
    #1 check("t5_grant_from0", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid[0] = 1'b0;
    #1 check("t5_c1_rv", 32'(bus.resp_valid), 32'h0);
    step();
    check("t5_c2_rv", 32'(bus.resp_valid), 32'h0);
    step();
    check("t5_rv0", 32'(bus.resp_valid), 32'h1);
    check("t5_y0", bus.resp_y, 32'h40100000);
    check("t5_grant3", 32'(bus.req_ready), 32'h8);
    step();
    bus.req_valid[3] = 1'b0;
    step();
    step();
    check("t5_rv3", 32'(bus.resp_valid), 32'h8);
    check("t5_y3", bus.resp_y, 32'h40000000);
    step();

    // 6: fairness, req1 held, req3 valid on even windows
    exp_g = '{4'h2, 4'h2, 4'h8, 4'h2, 4'h8, 4'h2, 4'h8, 4'h2};
    set_req(1, 1'b1, 32'h3F800000, 32'h40000000);
    set_req(3, 1'b1, 32'h3F800000, 32'h40000000);
    for (int j = 0; j < 8; j++) begin
      #1 check("t6_grant", 32'(bus.req_ready), 32'(exp_g[j]));
      step();
      if (exp_g[j] == 4'h8) bus.req_valid[3] = 1'b0;
      step();
      step();
      bus.req_valid[3] = (j % 2 == 1) && (j < 7);
      bus.req_valid[1] = (j < 7);
      #1 check("t6_rv", 32'(bus.resp_valid), 32'(exp_g[j]));
      check("t6_y", bus.resp_y, 32'h40000000);
    end
    step();
    check("t6_idle_rv", 32'(bus.resp_valid), 32'h0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
